// File: rtl/pipeline_pkg.sv
// Shared definitions for the RV32I pipeline: result-source selects, ALU
// operation encodings and the packed control bundle carried from D to E.
package pipeline_pkg;

    // Write-back result source select
    localparam logic [1:0] RESULT_SRC_ALU = 2'b00;
    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
    localparam logic [1:0] RESULT_SRC_PC4 = 2'b10;

    // ALU operation encodings
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    // Decoded control fields that travel together from D into E
    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic       alu_src;
        logic       jalr;
        logic [1:0] result_src;
        logic [3:0] alu_control;
        logic [2:0] funct3;
    } id_ex_ctrl_t;

    // A bubble does nothing: no writes, no memory, no control transfer
    localparam id_ex_ctrl_t CTRL_BUBBLE = '{
        reg_write:   1'b0,
        mem_write:   1'b0,
        jump:        1'b0,
        branch:      1'b0,
        alu_src:     1'b0,
        jalr:        1'b0,
        result_src:  RESULT_SRC_ALU,
        alu_control: ALU_ADD,
        funct3:      3'b000
    };

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection and fetch/decode stall/flush generation.
// Purely combinational. A redirect from execute wins over a load-use stall:
// the decode instruction is then wrong-path, so it is flushed, not held.
module hazard_detect
    import pipeline_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [1:0]        result_src_e_i,
    input  logic              valid_e_i,
    input  logic [REG_AW-1:0] rd_e_i,
    input  logic [REG_AW-1:0] rs1_d_i,
    input  logic [REG_AW-1:0] rs2_d_i,
    input  logic              pc_src_e_i,
    output logic              lw_stall_o,
    output logic              stall_f_o,
    output logic              stall_d_o,
    output logic              flush_d_o
);

    // Source compares are unconditional; a spurious stall costs one cycle
    // because the bubble it inserts clears ValidE.
    assign lw_stall_o = (result_src_e_i == RESULT_SRC_MEM) & valid_e_i &
                        (rd_e_i != '0) &
                        ((rd_e_i == rs1_d_i) | (rd_e_i == rs2_d_i));

    assign stall_f_o = lw_stall_o & ~pc_src_e_i;
    assign stall_d_o = lw_stall_o & ~pc_src_e_i;
    assign flush_d_o = pc_src_e_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use and redirect bubble insertion.
// Optional macro ID_EX_PERF_EN adds BubbleCntE/FlushCntE event counters.
module id_ex_stage
    import pipeline_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWriteD,
    input  logic              MemWriteD,
    input  logic              JumpD,
    input  logic              BranchD,
    input  logic              ALUSrcD,
    input  logic              JALRD,
    input  logic [1:0]        ResultSrcD,
    input  logic [3:0]        ALUControlD,
    input  logic [2:0]        funct3D,
    input  logic [XLEN-1:0]   RD1D,
    input  logic [XLEN-1:0]   RD2D,
    input  logic [XLEN-1:0]   PCD,
    input  logic [XLEN-1:0]   PCPlus4D,
    input  logic [XLEN-1:0]   ImmExtD,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdD,
    input  logic              PCSrcE,
    output logic              RegWriteE,
    output logic              MemWriteE,
    output logic              JumpE,
    output logic              BranchE,
    output logic              ALUSrcE,
    output logic              JALRE,
    output logic [1:0]        ResultSrcE,
    output logic [3:0]        ALUControlE,
    output logic [2:0]        funct3E,
    output logic [XLEN-1:0]   RD1E,
    output logic [XLEN-1:0]   RD2E,
    output logic [XLEN-1:0]   PCE,
    output logic [XLEN-1:0]   PCPlus4E,
    output logic [XLEN-1:0]   ImmExtE,
    output logic [REG_AW-1:0] Rs1E,
    output logic [REG_AW-1:0] Rs2E,
    output logic [REG_AW-1:0] RdE,
    output logic              ValidE,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD
`ifdef ID_EX_PERF_EN
    ,
    output logic [31:0]       BubbleCntE,
    output logic [31:0]       FlushCntE
`endif
);

    id_ex_ctrl_t       ctrl_d, ctrl_q;
    logic [XLEN-1:0]   rd1_d, rd1_q, rd2_d, rd2_q, pc_d, pc_q;
    logic [XLEN-1:0]   pc4_d, pc4_q, imm_d, imm_q;
    logic [REG_AW-1:0] rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
    logic              valid_d, valid_q;
    logic              lw_stall;
    logic              bubble;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .result_src_e_i (ctrl_q.result_src),
        .valid_e_i      (valid_q),
        .rd_e_i         (rd_q),
        .rs1_d_i        (Rs1D),
        .rs2_d_i        (Rs2D),
        .pc_src_e_i     (PCSrcE),
        .lw_stall_o     (lw_stall),
        .stall_f_o      (StallF),
        .stall_d_o      (StallD),
        .flush_d_o      (FlushD)
    );

    assign bubble = PCSrcE | lw_stall;

    // Next E contents: capture the decode bundle, or a cleared bubble
    always_comb begin
        // NOTE: every signal gets its default first so no path through this block can infer a latch.
        ctrl_d = '{
            reg_write:   RegWriteD,
            mem_write:   MemWriteD,
            jump:        JumpD,
            branch:      BranchD,
            alu_src:     ALUSrcD,
            jalr:        JALRD,
            result_src:  ResultSrcD,
            alu_control: ALUControlD,
            funct3:      funct3D
        };
        rd1_d   = RD1D;
        rd2_d   = RD2D;
        pc_d    = PCD;
        pc4_d   = PCPlus4D;
        imm_d   = ImmExtD;
        rs1_d   = Rs1D;
        rs2_d   = Rs2D;
        rd_d    = RdD;
        valid_d = 1'b1;
        if (bubble) begin
            ctrl_d  = CTRL_BUBBLE;
            rd1_d   = '0;
            rd2_d   = '0;
            pc_d    = '0;
            pc4_d   = '0;
            imm_d   = '0;
            rs1_d   = '0;
            rs2_d   = '0;
            rd_d    = '0;
            valid_d = 1'b0;
        end
    end

    // E-stage register bank; reset overrides bubble and capture
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
        if (rst) begin
            ctrl_q  <= CTRL_BUBBLE;
            rd1_q   <= '0;
            rd2_q   <= '0;
            pc_q    <= '0;
            pc4_q   <= '0;
            imm_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            imm_q   <= imm_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            valid_q <= valid_d;
        end
    end

    assign RegWriteE   = ctrl_q.reg_write;
    assign MemWriteE   = ctrl_q.mem_write;
    assign JumpE       = ctrl_q.jump;
    assign BranchE     = ctrl_q.branch;
    assign ALUSrcE     = ctrl_q.alu_src;
    assign JALRE       = ctrl_q.jalr;
    assign ResultSrcE  = ctrl_q.result_src;
    assign ALUControlE = ctrl_q.alu_control;
    assign funct3E     = ctrl_q.funct3;
    assign RD1E        = rd1_q;
    assign RD2E        = rd2_q;
    assign PCE         = pc_q;
    assign PCPlus4E    = pc4_q;
    assign ImmExtE     = imm_q;
    assign Rs1E        = rs1_q;
    assign Rs2E        = rs2_q;
    assign RdE         = rd_q;
    assign ValidE      = valid_q;

`ifdef ID_EX_PERF_EN
    logic [31:0] bubble_cnt_q, flush_cnt_q;

    // Event counters; a redirect coinciding with a load-use counts as a flush only
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else if (PCSrcE) begin
            flush_cnt_q  <= flush_cnt_q + 32'd1;
        end else if (lw_stall) begin
            bubble_cnt_q <= bubble_cnt_q + 32'd1;
        end
    end

    assign BubbleCntE = bubble_cnt_q;
    assign FlushCntE  = flush_cnt_q;
`endif

endmodule
